fifo_reader: RTL and testbench

Read-side drain engine for the team's synchronous FIFO (`My_FIFO`). It watches the FIFO's empty flag and issues read strobes. It captures each word one cycle after its strobe and presents the words in order on a valid/ready stream towards downstream logic. A 2-entry skid buffer absorbs the FIFO read latency, so the block sustains one word per cycle while `ready_i` stays high.

---
 rtl/fifo_reader_pkg.sv | 22 ++
 rtl/fifo_reader_skid.sv | 76 +++++++
 rtl/fifo_reader.sv | 86 ++++++++
 tb/tb_fifo_reader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared constants, types and the read-credit helper for
// the fifo_reader drain engine.
package fifo_reader_pkg;

    // Number of words the skid buffer can hold.
    localparam int SKID_DEPTH = 2;

    // Skid buffer occupancy, 0..SKID_DEPTH.
    typedef logic [1:0] occ_t;

    // A new read may be issued only if every word already committed to the
    // buffer (held words plus the one still in flight from the FIFO), minus
    // the word leaving this cycle, leaves room for one more.
    function automatic logic read_credit_ok(input occ_t occ,
                                            input logic inflight,
                                            input logic pop);
        logic [2:0] committed;
        committed = {1'b0, occ} + {2'b00, inflight};
        return committed < (3'(SKID_DEPTH) + {2'b00, pop});
    endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: two-entry skid buffer (head/tail slots) that absorbs the
// one-cycle read latency of the FIFO. The head slot drives the output stream
// and keeps its last value once the buffer drains.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int Data_Width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [Data_Width-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [1:0]            occ_o,
    output logic [Data_Width-1:0] head_o
);

    occ_t                  occ_q, occ_d;
    logic [Data_Width-1:0] head_q, head_d;
    logic [Data_Width-1:0] tail_q, tail_d;

    logic                  pop_eff;
    occ_t                  occ_after_pop;
    logic [2:0]            occ_sum;

    // Apply pop first, then place the captured word into whichever slot is
    // next free after that pop.
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        pop_eff       = pop_i && (occ_q != 2'd0);
        occ_after_pop = occ_q - {1'b0, pop_eff};

        // Only a full buffer has a tail word to promote; with one word the
        // head keeps the delivered value.
        if (pop_eff && (occ_q == 2'd2)) begin
            head_d = tail_q;
        end

        if (push_i) begin
            if (occ_after_pop == 2'd0) begin
                head_d = push_data_i;
            end else begin
                tail_d = push_data_i;
            end
        end

        occ_sum = {1'b0, occ_after_pop} + {2'b00, push_i};
        occ_d   = occ_sum[1:0];
    end

    // Buffer state register; reset empties the buffer and clears both slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Overflow past the two slots means the read credit logic is broken.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (occ_sum <= 3'(SKID_DEPTH))
                else $error("fifo_reader_skid: occupancy overflow");
        end
    end

    assign occ_o  = occ_q;
    assign head_o = head_q;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: read-side drain engine for the synchronous FIFO. Issues read
// strobes while the FIFO is non-empty and buffer credit remains, captures
// each word one cycle after its strobe and presents the words in order on a
// valid/ready stream.
// Optional feature: define FIFO_READER_CNT_EN to add the rd_count_o
// delivered-word counter (Count_Width bits, wrapping).
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int Data_Width  = 16
`ifdef FIFO_READER_CNT_EN
   ,parameter int Count_Width = 8
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fifo_empty_i,
    output logic                   fifo_r_o,
    input  logic [Data_Width-1:0]  fifo_data_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [Data_Width-1:0]  data_out
`ifdef FIFO_READER_CNT_EN
   ,output logic [Count_Width-1:0] rd_count_o
`endif
);

    logic [1:0] occ;
    logic       pop;
    logic       fifo_r;
    logic       inflight_q, inflight_d;

    assign valid_o = (occ != 2'd0);
    assign pop     = valid_o && ready_i;

    // Read strobe: never into an empty FIFO, never during reset, and only
    // while the buffer still has room for the word it would return.
    always_comb begin
        fifo_r     = !reset && !fifo_empty_i && read_credit_ok(occ, inflight_q, pop);
        inflight_d = fifo_r;
    end

    assign fifo_r_o = fifo_r;

    // Tracks the word the FIFO returns on the cycle after a strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_reader_skid #(
        .Data_Width (Data_Width)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i (fifo_data_i),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (data_out)
    );

`ifdef FIFO_READER_CNT_EN
    logic [Count_Width-1:0] cnt_q, cnt_d;

    // Delivered-word count, wrapping naturally at 2^Count_Width.
    always_comb begin
        cnt_d = cnt_q + {{(Count_Width-1){1'b0}}, pop};
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: scoreboard bench for fifo_reader with a behavioural
// one-cycle-latency FIFO model on the read side.
module tb_fifo_reader;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_empty_i;
    logic          fifo_r_o;
    logic [DW-1:0] fifo_data_i = '0;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] data_out;
`ifdef FIFO_READER_CNT_EN
    logic [7:0]    rd_count_o;
`endif

    always #5 clk = ~clk;

    fifo_reader dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty_i (fifo_empty_i),
        .fifo_r_o     (fifo_r_o),
        .fifo_data_i  (fifo_data_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_out     (data_out)
`ifdef FIFO_READER_CNT_EN
       ,.rd_count_o   (rd_count_o)
`endif
    );

    // FIFO model: writes come from the stimulus process, reads from the strobe.
    logic [DW-1:0] mem [0:1023];
    int            pushed_n = 0;
    int            popped_n = 0;
    logic          fifo_clr = 1'b0;

    assign fifo_empty_i = (pushed_n == popped_n);

    always @(posedge clk) begin
        if (fifo_clr) begin
            popped_n <= pushed_n;
        end else if (fifo_r_o && !fifo_empty_i) begin
            fifo_data_i <= mem[popped_n];
            popped_n    <= popped_n + 1;
        end
    end

    // Scoreboard and bookkeeping.
    logic [DW-1:0] exp_q [$];
    int            total = 0;
    int            bad = 0;
    int            strobes = 0;
    int            delivered = 0;
    logic [7:0]    exp_cnt = 8'd0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        mem[pushed_n] = w;
        pushed_n++;
        exp_q.push_back(w);
    endtask

    // One clock: inputs are already set; sample just after the falling edge,
    // monitor the transfer that the next rising edge will perform, then
    // advance to the following falling edge.
    task automatic tick();
        #1;
        if (!reset) begin
`ifdef FIFO_READER_CNT_EN
            check("rd_count", rd_count_o, exp_cnt);
`endif
            if (fifo_r_o) strobes++;
            if (fifo_empty_i) check("no_rd_when_empty", fifo_r_o, 0);
            check("occ_le_2", dut.u_skid.occ_q <= 2'd2, 1);
            if (hold_prev) begin
                check("hold_valid", valid_o, 1);
                check("hold_data", data_out, data_prev);
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) check("spurious_word", valid_o, 0);
                else check("data", data_out, exp_q.pop_front());
                delivered++;
                exp_cnt++;
            end
            hold_prev = valid_o && !ready_i;
            data_prev = data_out;
        end else begin
            hold_prev = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n, input bit clr_fifo);
        reset    = 1'b1;
        fifo_clr = clr_fifo;
        if (clr_fifo) exp_q.delete();
        for (int i = 0; i < n; i++) begin
            #1;
            check("rst_rd", fifo_r_o, 0);
            if (i > 0) begin
                check("rst_valid", valid_o, 0);
                check("rst_data", data_out, 0);
`ifdef FIFO_READER_CNT_EN
                check("rst_count", rd_count_o, 0);
`endif
            end
            @(negedge clk);
        end
        reset     = 1'b0;
        fifo_clr  = 1'b0;
        exp_cnt   = 8'd0;
        hold_prev = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int nxt;
        int base;

        reset   = 1'b1;
        ready_i = 1'b1;
        @(negedge clk);

        // Reset with a non-empty FIFO, then the first post-reset strobe.
        push_word(16'h0F0F);
        do_reset(2, 1'b0);
        #1 check("rd_first_after_reset", fifo_r_o, 1);
        wait_drain(10);

        // Two words, ready held high: back-to-back strobes and deliveries.
        strobes = 0;
        push_word(16'hABAB);
        push_word(16'h32EF);
        #1 check("t2_rd_c0", fifo_r_o, 1);
        tick();
        #1 check("t2_rd_c1", fifo_r_o, 1);
        check("t2_valid_c1", valid_o, 0);
        tick();
        #1 check("t2_valid_c2", valid_o, 1);
        check("t2_data_c2", data_out, 16'hABAB);
        tick();
        #1 check("t2_data_c3", data_out, 16'h32EF);
        tick();
        tick();
        check("t2_strobes", strobes, 2);
`ifdef FIFO_READER_CNT_EN
        #1 check("t2_count", rd_count_o, 2);
`endif

        // Backpressure: a third word stays in the FIFO while two are held.
        ready_i = 1'b0;
        strobes = 0;
        push_word(16'hABAB);
        push_word(16'h32EF);
        push_word(16'h5555);
        repeat (5) tick();
        check("bp_strobes", strobes, 2);
        #1 check("bp_rd_low", fifo_r_o, 0);
        check("bp_valid", valid_o, 1);
        check("bp_head", data_out, 16'hABAB);
        ready_i = 1'b1;
        wait_drain(20);

        // Empty FIFO: no strobes, no valid; then the fill latency.
        for (int i = 0; i < 10; i++) begin
            #1 check("idle_rd", fifo_r_o, 0);
            check("idle_valid", valid_o, 0);
            tick();
        end
        push_word(16'hDDDD);
        n = 0;
        while (n < 10) begin
            #1;
            if (valid_o) break;
            tick();
            n++;
        end
        check("fill_latency", n, 2);
        wait_drain(10);

        // Reset with a full buffer, then a fresh word.
        ready_i = 1'b0;
        push_word(16'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        repeat (4) tick();
        #1 check("pre_rst_occ", dut.u_skid.occ_q, 2);
        do_reset(1, 1'b1);
        #1 check("post_rst_valid", valid_o, 0);
        check("post_rst_data", data_out, 0);
        ready_i = 1'b1;
        push_word(16'h1234);
        wait_drain(10);

        // Random ready, incrementing pattern of 200 words.
        base = delivered;
        nxt  = 0;
        n    = 0;
        while ((nxt < 200 || exp_q.size() != 0) && n < 5000) begin
            ready_i = 1'($urandom_range(0, 1));
            if (nxt < 200 && $urandom_range(0, 9) < 6) begin
                push_word(16'(nxt));
                nxt++;
            end
            tick();
            n++;
        end
        check("rand_left", exp_q.size(), 0);
        check("rand_delivered", delivered - base, 200);
        ready_i = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
